add_round_key_stage: RTL and testbench

ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/sub_word.sv | 13 +
 rtl/add_round_key_stage.sv | 99 +++++++++
 tb/tb_add_round_key_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants: widths, round count, S-box and round-constant lookup.
package aes_pkg;

    localparam int STATE_W = 128;
    localparam int KEY_W   = 128;
    localparam logic [3:0] NUM_ROUNDS = 4'd10;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Round constant used when stepping from round rnd to rnd+1.
    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        case (rnd)
            4'd0:    rcon_of = 8'h01;
            4'd1:    rcon_of = 8'h02;
            4'd2:    rcon_of = 8'h04;
            4'd3:    rcon_of = 8'h08;
            4'd4:    rcon_of = 8'h10;
            4'd5:    rcon_of = 8'h20;
            4'd6:    rcon_of = 8'h40;
            4'd7:    rcon_of = 8'h80;
            4'd8:    rcon_of = 8'h1b;
            4'd9:    rcon_of = 8'h36;
            default: rcon_of = 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational AES SubWord: S-box applied independently to each byte of a 32-bit word.
module sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_in,
    output logic [31:0] word_out
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign word_out[8*b +: 8] = SBOX[word_in[8*b +: 8]];
    end

endmodule

// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage with on-the-fly key expansion and a one-deep output register.
// Build option: define ADD_ROUND_KEY_LOCK_EN to ignore key_load while a round sequence is in flight.
module add_round_key_stage
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               key_load,
    input  logic [KEY_W-1:0]   cipher_key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [3:0]         out_round,
    output logic               out_last
);

    logic [KEY_W-1:0]   key_copy;
    logic [KEY_W-1:0]   rk;
    logic [KEY_W-1:0]   rk_next;
    logic [3:0]         rnd;
    logic               key_valid;
    logic               key_load_eff;
    logic               accept;
    logic [31:0]        sw_out;
    logic [31:0]        t_word;
    logic [31:0]        w0n, w1n, w2n, w3n;

    logic [STATE_W-1:0] state_p1;
    logic [3:0]         round_p1;
    logic               vld_p1;

`ifdef ADD_ROUND_KEY_LOCK_EN
    assign key_load_eff = key_load && (rnd == 4'd0) && !vld_p1;
`else
    assign key_load_eff = key_load;
`endif

    assign in_ready = (!vld_p1 || out_ready) && !key_load_eff && key_valid;
    assign accept   = in_valid && in_ready;

    // RotWord moves byte 1 into byte 0, so the low byte of w3 ends up on top.
    sub_word u_sub_word (
        .word_in  ({rk[103:96], rk[127:104]}),
        .word_out (sw_out)
    );

    assign t_word  = sw_out ^ {24'h0, rcon_of(rnd)};
    assign w0n     = rk[31:0]   ^ t_word;
    assign w1n     = rk[63:32]  ^ w0n;
    assign w2n     = rk[95:64]  ^ w1n;
    assign w3n     = rk[127:96] ^ w2n;
    assign rk_next = {w3n, w2n, w1n, w0n};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_copy  <= '0;
            rk        <= '0;
            rnd       <= 4'd0;
            key_valid <= 1'b0;
        end else if (key_load_eff) begin
            key_copy  <= cipher_key;
            rk        <= cipher_key;
            rnd       <= 4'd0;
            key_valid <= 1'b1;
        end else if (accept) begin
            if (rnd == NUM_ROUNDS) begin
                rnd <= 4'd0;
                rk  <= key_copy;
            end else begin
                rnd <= rnd + 4'd1;
                rk  <= rk_next;
            end
        end
    end

    // Output stage boundary: result register, replaced on accept, emptied on drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1 <= '0;
            round_p1 <= 4'd0;
            vld_p1   <= 1'b0;
        end else if (accept) begin
            state_p1 <= in_state ^ rk;
            round_p1 <= rnd;
            vld_p1   <= 1'b1;
        end else if (out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_state = state_p1;
    assign out_round = round_p1;
    assign out_last  = (round_p1 == NUM_ROUNDS);

endmodule

// File: tb/tb_add_round_key_stage.sv
// Scoreboard bench for add_round_key_stage: key schedule model built from GF(2^8) arithmetic.
module tb_add_round_key_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] cipher_key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;

    add_round_key_stage dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .cipher_key (cipher_key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .out_round  (out_round),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic [3:0]   rn;
    } exp_t;

    exp_t         q[$];
    logic [7:0]   sb [256];
    logic [127:0] rks [11];
    int           n_chk = 0;
    int           n_fail = 0;
    bit           m_kv = 0;
    bit           m_v = 0;
    int           m_r = 0;

    localparam logic [127:0] FIPS_KEY = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    localparam logic [127:0] FIPS_R1  = 128'hfe76abd6_f178a6da_fa72afd2_fd74aad6;
    localparam logic [127:0] FIPS_R10 = 128'hc5302b4d_8ba707f3_174a94e3_7f1d1113;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Full FIPS-197 expansion into an array of eleven round keys.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[7:0], t[31:8]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[7:0] ^= rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rks[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    // One clock of stimulus; the model decides acceptance from the handshake rules.
    task automatic step(input logic kl, input logic [127:0] ck, input logic iv,
                        input logic [127:0] st, input logic ordy);
        bit exp_rdy;
        key_load = kl; cipher_key = ck; in_valid = iv; in_state = st; out_ready = ordy;
        @(negedge clk);
        exp_rdy = m_kv && !kl && (!m_v || ordy);
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        check("out_valid", 128'(out_valid), 128'(m_v));
        if (iv && exp_rdy) begin
            q.push_back('{st: st ^ rks[m_r], rn: 4'(m_r)});
            m_r = (m_r == 10) ? 0 : m_r + 1;
            m_v = 1;
        end else if (ordy) begin
            m_v = 0;
        end
        if (kl) begin
            expand(ck);
            m_r = 0;
            m_kv = 1;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: out_valid=1 with nothing expected at %0t", $time);
            end else begin
                check("sb_state", out_state, q[0].st);
                check("sb_round", 128'(out_round), 128'(q[0].rn));
                check("sb_last", 128'(out_last), 128'(q[0].rn == 4'd10));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k2, k3, st;
        rst = 1'b0; key_load = 0; cipher_key = '0; in_valid = 0; in_state = '0; out_ready = 0;
        build_sbox();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_state", out_state, 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // FIPS key and eleven-plus zero states back to back
        step(1, FIPS_KEY, 0, '0, 1);
        for (int i = 0; i < 12; i++) begin
            step(0, '0, 1, '0, 1);
            if (i == 0)  check("fips_r0", out_state, FIPS_KEY);
            if (i == 1)  check("fips_r1", out_state, FIPS_R1);
            if (i == 10) begin
                check("fips_r10", out_state, FIPS_R10);
                check("fips_last", 128'(out_last), 128'd1);
            end
            if (i == 11) begin
                check("wrap_r0", out_state, FIPS_KEY);
                check("wrap_round", 128'(out_round), 128'd0);
            end
        end

        // Backpressure: out_ready low for three cycles with input pending
        step(0, '0, 1, {4{$urandom}}, 1);
        repeat (3) step(0, '0, 1, {4{$urandom}}, 0);
        repeat (3) step(0, '0, 1, {4{$urandom}}, 1);

        // key_load collides with in_valid at round 4
        k2 = {$urandom, $urandom, $urandom, $urandom};
        k3 = {$urandom, $urandom, $urandom, $urandom};
        step(1, k2, 0, '0, 1);
        repeat (4) step(0, '0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
        step(1, k3, 1, {4{$urandom}}, 1);
        st = {$urandom, $urandom, $urandom, $urandom};
        step(0, '0, 1, st, 1);
        check("reload_round", 128'(out_round), 128'd0);
        check("reload_state", out_state, st ^ k3);

        // Asynchronous reset at round 7
        step(1, k2, 0, '0, 1);
        repeat (7) step(0, '0, 1, {$urandom, $urandom, $urandom, $urandom}, 1);
        in_valid = 0;
        #2;
        rst = 1'b0;
        q.delete();
        m_kv = 0; m_v = 0; m_r = 0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_out_state", out_state, 128'd0);
        check("arst_out_round", 128'(out_round), 128'd0);
        check("arst_out_last", 128'(out_last), 128'd0);
        check("arst_in_ready", 128'(in_ready), 128'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) step(0, '0, 1, {4{$urandom}}, 1);

        // Randomized traffic
        step(1, {$urandom, $urandom, $urandom, $urandom}, 0, '0, 1);
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 25) == 0, {$urandom, $urandom, $urandom, $urandom},
                 ($urandom % 10) < 7, {$urandom, $urandom, $urandom, $urandom},
                 ($urandom % 10) < 7);
        end
        repeat (2) step(0, '0, 0, '0, 1);
        check("queue_empty", 128'(q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
